ps2_cmd_arbiter: RTL and testbench

- Shares the single PS/2 host-to-device transmitter on PS2_CLK/PS2_DAT between the keyboard and mouse front-ends.
- Runs a one-shot boot command that enables mouse streaming, then round-robins command requests from both sides.
- Waits for the device acknowledge byte, retries on resend or timeout, and reports done or error to each requester.
- While a command is in flight, it flags received bytes as command responses so the keyboard/mouse decoders drop them.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_ack_timer.sv | 28 ++
 rtl/ps2_cmd_arbiter.sv | 134 +++++++++++++
 tb/tb_ps2_cmd_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encoding and protocol byte constants
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_SEND,
    ST_WAIT_SENT,
    ST_WAIT_ACK,
    ST_FINISH
  } arb_state_t;

  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_FAIL     = 8'hFC;

  localparam logic [7:0] PS2_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_RESET    = 8'hFF;
  localparam logic [7:0] PS2_SET_LEDS = 8'hED;

endpackage

// File: rtl/ps2_ack_timer.sv
// rtl/ps2_ack_timer.sv - clearable saturating counter flagging the response timeout
module ps2_ack_timer #(
  parameter int LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic timeout
);

  localparam logic [19:0] LAST = 20'(LIMIT - 1);

  logic [19:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && count != LAST) begin
      count <= count + 20'd1;
    end
  end

  assign timeout = (count == LAST);

endmodule

// File: rtl/ps2_cmd_arbiter.sv
// rtl/ps2_cmd_arbiter.sv - shares the PS/2 transmitter between keyboard and mouse,
// issues the boot enable command, and retries on resend/timeout
module ps2_cmd_arbiter
  import ps2_pkg::*;
#(
  parameter logic [7:0] BOOT_CMD    = PS2_ENABLE,
  parameter int         ACK_TIMEOUT = 1_000_000,
  parameter int         MAX_RETRY   = 2
) (
  input  logic       CLOCK_50,
  input  logic       KEY,
  input  logic       kb_req,
  input  logic [7:0] kb_cmd,
  output logic       kb_done,
  output logic       kb_err,
  input  logic       ms_req,
  input  logic [7:0] ms_cmd,
  output logic       ms_done,
  output logic       ms_err,
  output logic [7:0] tx_cmd,
  output logic       tx_send,
  input  logic       tx_sent,
  input  logic       tx_error,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rsp_owned,
  output logic       busy,
  output logic       owner
);

  arb_state_t state;
  logic [3:0] retry_cnt;
  logic       timeout;

  logic in_ack, in_sent;
  logic attempt_ok, hard_fail, attempt_fail, retries_left, grant_ms;

  assign in_ack  = (state == ST_WAIT_ACK);
  assign in_sent = (state == ST_WAIT_SENT);

  assign attempt_ok   = in_ack && rx_valid && rx_data == PS2_ACK;
  assign hard_fail    = in_ack && rx_valid && rx_data == PS2_FAIL;
  assign attempt_fail = (in_sent && tx_error) ||
                        (in_ack && ((rx_valid && rx_data == PS2_RESEND) || timeout));
  assign retries_left = (retry_cnt < 4'(MAX_RETRY));

  // Round-robin: on a tie, serve the side that did not own the last transaction.
  assign grant_ms = ms_req && (!kb_req || !owner);

  ps2_ack_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
    .clk     (CLOCK_50),
    .rst_n   (KEY),
    .clear   (in_sent && tx_sent && !tx_error),
    .en      (in_ack),
    .timeout (timeout)
  );

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state     <= ST_BOOT;
      tx_cmd    <= 8'h00;
      tx_send   <= 1'b0;
      kb_done   <= 1'b0;
      kb_err    <= 1'b0;
      ms_done   <= 1'b0;
      ms_err    <= 1'b0;
      busy      <= 1'b1;
      rsp_owned <= 1'b0;
      owner     <= 1'b1;
      retry_cnt <= 4'd0;
    end else begin
      tx_send <= 1'b0;
      kb_done <= 1'b0;
      kb_err  <= 1'b0;
      ms_done <= 1'b0;
      ms_err  <= 1'b0;

      case (state)
        ST_BOOT: begin
          tx_cmd    <= BOOT_CMD;
          owner     <= 1'b1;
          retry_cnt <= 4'd0;
          tx_send   <= 1'b1;
          state     <= ST_SEND;
        end

        ST_IDLE: begin
          if (kb_req || ms_req) begin
            owner     <= grant_ms;
            tx_cmd    <= grant_ms ? ms_cmd : kb_cmd;
            retry_cnt <= 4'd0;
            tx_send   <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_SEND;
          end
        end

        ST_SEND: state <= ST_WAIT_SENT;

        ST_WAIT_SENT, ST_WAIT_ACK: begin
          // Completion pulses are raised on entry to FINISH so the requester
          // can drop req before IDLE looks at it again.
          if (attempt_ok) begin
            kb_done   <= !owner;
            ms_done   <= owner;
            rsp_owned <= 1'b0;
            state     <= ST_FINISH;
          end else if (hard_fail || (attempt_fail && !retries_left)) begin
            kb_err    <= !owner;
            ms_err    <= owner;
            rsp_owned <= 1'b0;
            state     <= ST_FINISH;
          end else if (attempt_fail) begin
            retry_cnt <= retry_cnt + 4'd1;
            tx_send   <= 1'b1;
            rsp_owned <= 1'b0;
            state     <= ST_SEND;
          end else if (in_sent && tx_sent) begin
            rsp_owned <= 1'b1;
            state     <= ST_WAIT_ACK;
          end
        end

        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// tb/tb_ps2_cmd_arbiter.sv - scoreboard bench for ps2_cmd_arbiter
module tb_ps2_cmd_arbiter;

  logic       CLOCK_50 = 1'b0;
  logic       KEY      = 1'b0;
  logic       kb_req   = 1'b0;
  logic [7:0] kb_cmd   = 8'h00;
  logic       ms_req   = 1'b0;
  logic [7:0] ms_cmd   = 8'h00;
  logic       tx_sent  = 1'b0;
  logic       tx_error = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       kb_done, kb_err, ms_done, ms_err;
  logic [7:0] tx_cmd;
  logic       tx_send, rsp_owned, busy, owner;

  localparam logic [7:0] EV_SEND    = 8'd1;
  localparam logic [7:0] EV_KB_DONE = 8'd2;
  localparam logic [7:0] EV_KB_ERR  = 8'd3;
  localparam logic [7:0] EV_MS_DONE = 8'd4;
  localparam logic [7:0] EV_MS_ERR  = 8'd5;

  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] exp_q[$];

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_cmd_arbiter #(.ACK_TIMEOUT(100)) dut (
    .CLOCK_50  (CLOCK_50),
    .KEY       (KEY),
    .kb_req    (kb_req),
    .kb_cmd    (kb_cmd),
    .kb_done   (kb_done),
    .kb_err    (kb_err),
    .ms_req    (ms_req),
    .ms_cmd    (ms_cmd),
    .ms_done   (ms_done),
    .ms_err    (ms_err),
    .tx_cmd    (tx_cmd),
    .tx_send   (tx_send),
    .tx_sent   (tx_sent),
    .tx_error  (tx_error),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rsp_owned (rsp_owned),
    .busy      (busy),
    .owner     (owner)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic observe(input logic [7:0] kind, input logic [7:0] data);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: got %0h expected none", {kind, data});
    end else begin
      e = exp_q.pop_front();
      check("event", {16'h0, kind, data}, {16'h0, e});
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (KEY) begin
      if (tx_send) observe(EV_SEND, tx_cmd);
      if (kb_done) observe(EV_KB_DONE, 8'h00);
      if (kb_err)  observe(EV_KB_ERR, 8'h00);
      if (ms_done) observe(EV_MS_DONE, 8'h00);
      if (ms_err)  observe(EV_MS_ERR, 8'h00);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_tx_send();
    int n = 0;
    while (!tx_send && n < 3000) begin
      tick(1);
      n++;
    end
    if (!tx_send) begin
      n_total++;
      $display("FAIL tx_send_wait: got no strobe expected strobe");
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(kb_done || kb_err || ms_done || ms_err) && n < 3000) begin
      tick(1);
      n++;
    end
    if (kb_done || kb_err) kb_req = 1'b0;
    if (ms_done || ms_err) ms_req = 1'b0;
    if (!(kb_done || kb_err || ms_done || ms_err)) begin
      n_total++;
      $display("FAIL completion_wait: got no pulse expected pulse");
    end
  endtask

  task automatic pulse_sent(input int dly);
    tick(dly);
    tx_sent = 1'b1;
    tick(1);
    tx_sent = 1'b0;
  endtask

  task automatic pulse_rx(input int dly, input logic [7:0] b);
    tick(dly);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] kind, input logic [7:0] data);
    exp_q.push_back({kind, data});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("rst_busy", busy, 1);
    check("rst_rsp_owned", rsp_owned, 0);
    check("rst_owner", owner, 1);
    check("rst_tx_cmd", tx_cmd, 8'h00);
    check("rst_pulses", {tx_send, kb_done, kb_err, ms_done, ms_err}, 5'b0);

    // Boot path
    push(EV_SEND, 8'hF4);
    push(EV_MS_DONE, 8'h00);
    KEY = 1'b1;
    wait_tx_send();
    pulse_sent(5);
    pulse_rx(10, 8'hFA);
    wait_done();
    tick(1);
    check("boot_busy", busy, 0);
    check("boot_owner", owner, 1);

    // Simultaneous requests: owner was mouse, so keyboard goes first
    push(EV_SEND, 8'hED);
    push(EV_KB_DONE, 8'h00);
    push(EV_SEND, 8'hF5);
    push(EV_MS_DONE, 8'h00);
    kb_cmd = 8'hED; kb_req = 1'b1;
    ms_cmd = 8'hF5; ms_req = 1'b1;
    wait_tx_send();
    pulse_sent(3);
    pulse_rx(4, 8'hFA);
    wait_done();
    wait_tx_send();
    pulse_sent(3);
    pulse_rx(4, 8'hFA);
    wait_done();
    tick(1);
    check("rr_owner", owner, 1);

    // Resend twice then ACK
    for (int i = 0; i < 3; i++) push(EV_SEND, 8'hED);
    push(EV_KB_DONE, 8'h00);
    kb_cmd = 8'hED; kb_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_tx_send();
      pulse_sent(2);
      pulse_rx(3, (i == 2) ? 8'hFA : 8'hFE);
    end
    wait_done();
    tick(1);
    check("resend_owner", owner, 0);

    // Timeout on every attempt
    for (int i = 0; i < 3; i++) push(EV_SEND, 8'hF2);
    push(EV_MS_ERR, 8'h00);
    ms_cmd = 8'hF2; ms_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_tx_send();
      pulse_sent(2);
      tick(5);
      check("timeout_rsp_owned_wait", rsp_owned, 1);
    end
    wait_done();
    tick(1);
    check("timeout_rsp_owned_after", rsp_owned, 0);
    check("timeout_busy_after", busy, 0);

    // Foreign byte ignored, hard fail without retry
    push(EV_SEND, 8'hFF);
    push(EV_KB_ERR, 8'h00);
    kb_cmd = 8'hFF; kb_req = 1'b1;
    wait_tx_send();
    pulse_sent(2);
    pulse_rx(3, 8'h08);
    tick(3);
    check("foreign_still_waiting", rsp_owned, 1);
    pulse_rx(1, 8'hFC);
    wait_done();
    tick(4);
    check("hardfail_idle", busy, 0);

    // Reset while waiting for the response
    push(EV_SEND, 8'hEE);
    ms_cmd = 8'hEE; ms_req = 1'b1;
    wait_tx_send();
    pulse_sent(2);
    tick(3);
    check("pre_reset_rsp_owned", rsp_owned, 1);
    #2;
    KEY = 1'b0;
    #1;
    check("async_rsp_owned", rsp_owned, 0);
    check("async_pulses", {tx_send, kb_done, kb_err, ms_done, ms_err}, 5'b0);
    check("async_tx_cmd", tx_cmd, 8'h00);
    check("async_busy", busy, 1);
    ms_req = 1'b0;
    tick(2);
    push(EV_SEND, 8'hF4);
    push(EV_MS_DONE, 8'h00);
    KEY = 1'b1;
    wait_tx_send();
    pulse_sent(5);
    pulse_rx(10, 8'hFA);
    wait_done();
    tick(2);
    check("reboot_busy", busy, 0);
    check("reboot_owner", owner, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
